// File: rtl/mfp_sevenseg_arbiter.sv
// Purpose: arbitrates the seven-segment display between two sources with a lease and a blanking gap.
// Latency: one cycle from sampled request/data to registered grant and display outputs.
// Backpressure: none; requesters hold req high and keep content valid until granted.
module mfp_sevenseg_arbiter #(
  parameter int HOLD_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  en0,
  input  logic [7:0]  en1,
  input  logic [63:0] digits0,
  input  logic [63:0] digits1,
  input  logic [7:0]  dp0,
  input  logic [7:0]  dp1,
  output logic [1:0]  gnt,
  output logic [7:0]  seg_en,
  output logic [63:0] seg_data,
  output logic [7:0]  seg_dp
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int BW = $clog2(BLANK_CYCLES + 1);

  // The lease counter holds the number of completed grant cycles before the
  // current one, so the lease is up once it reaches HOLD_CYCLES-1.
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_CYCLES);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    BLANK  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [BW-1:0] blank_q, blank_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [7:0]    seg_en_q, seg_en_d;
  logic [63:0]   seg_data_q, seg_data_d;
  logic [7:0]    seg_dp_q, seg_dp_d;

  logic pick_vld;
  logic pick;
  logic own_req;
  logic oth_req;
  logic lease_up;

  // Next-state, round-robin pointer, counters, and registered outputs derived from the next state.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    hold_d     = hold_q;
    blank_d    = blank_q;
    gnt_d      = 2'b00;
    seg_en_d   = 8'h00;
    seg_dp_d   = 8'h00;
    seg_data_d = seg_data_q;

    // Sole requester wins; with both active, the one not granted last wins.
    pick_vld = req0 | req1;
    pick     = (req0 && req1) ? ~last_q : req1;

    own_req  = (state_q == GRANT1) ? req1 : req0;
    oth_req  = (state_q == GRANT1) ? req0 : req1;
    lease_up = (hold_q >= HOLD_LAST);

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = pick ? GRANT1 : GRANT0;
          last_d  = pick;
          hold_d  = '0;
        end
      end
      GRANT0, GRANT1: begin
        // Release and lease expiry together still make one move to BLANK.
        if (!own_req || (lease_up && oth_req)) begin
          state_d = BLANK;
          blank_d = '0;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end
      BLANK: begin
        if (blank_q == BLANK_LAST) begin
          if (pick_vld) begin
            state_d = pick ? GRANT1 : GRANT0;
            last_d  = pick;
            hold_d  = '0;
          end else begin
            state_d = IDLE;
          end
          blank_d = '0;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Display content follows the owner every granted cycle; blank/idle keep data but disable digits.
    case (state_d)
      GRANT0: begin
        gnt_d      = 2'b01;
        seg_en_d   = en0;
        seg_dp_d   = dp0;
        seg_data_d = digits0;
      end
      GRANT1: begin
        gnt_d      = 2'b10;
        seg_en_d   = en1;
        seg_dp_d   = dp1;
        seg_data_d = digits1;
      end
      default: ;
    endcase
  end

  // State and output registers with synchronous reset overriding every transition.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      hold_q     <= '0;
      blank_q    <= '0;
      gnt_q      <= 2'b00;
      seg_en_q   <= 8'h00;
      seg_data_q <= 64'h0;
      seg_dp_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hold_q     <= hold_d;
      blank_q    <= blank_d;
      gnt_q      <= gnt_d;
      seg_en_q   <= seg_en_d;
      seg_data_q <= seg_data_d;
      seg_dp_q   <= seg_dp_d;
    end
  end

  assign gnt      = gnt_q;
  assign seg_en   = seg_en_q;
  assign seg_data = seg_data_q;
  assign seg_dp   = seg_dp_q;

endmodule

// File: tb/tb_mfp_sevenseg_arbiter.sv
// Purpose: directed bench for mfp_sevenseg_arbiter with a per-cycle behavioural model.
// Latency: model predicts outputs one edge after inputs are sampled.
// Backpressure: not applicable; requests are driven as levels.
module tb_mfp_sevenseg_arbiter;

  localparam int HOLD  = 8;
  localparam int BLANK = 2;

  logic        HCLK;
  logic        HRESET;
  logic        req0, req1;
  logic [7:0]  en0, en1;
  logic [63:0] digits0, digits1;
  logic [7:0]  dp0, dp1;
  logic [1:0]  gnt;
  logic [7:0]  seg_en;
  logic [63:0] seg_data;
  logic [7:0]  seg_dp;

  int n_vec;
  int n_bad;

  mfp_sevenseg_arbiter #(
    .HOLD_CYCLES (HOLD),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .req0    (req0),
    .req1    (req1),
    .en0     (en0),
    .en1     (en1),
    .digits0 (digits0),
    .digits1 (digits1),
    .dp0     (dp0),
    .dp1     (dp1),
    .gnt     (gnt),
    .seg_en  (seg_en),
    .seg_data(seg_data),
    .seg_dp  (seg_dp)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Behavioural model: who owns the display, how long, and how much gap remains.
  int          m_owner;   // -1 none, else requester index
  int          m_held;    // grant cycles completed by the current owner
  int          m_gap;     // blank cycles still to run
  int          m_last;
  int          m_win;
  logic [1:0]  e_gnt;
  logic [7:0]  e_en;
  logic [7:0]  e_dp;
  logic [63:0] e_data;

  function automatic int arb(input logic r0, input logic r1, input int last);
    if (r0 && r1) return 1 - last;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  function automatic logic req_of(input int i);
    return (i == 0) ? req0 : req1;
  endfunction

  // Advance the model at each rising edge using the inputs seen at that edge.
  always @(posedge HCLK) begin
    if (HRESET) begin
      m_owner = -1; m_held = 0; m_gap = 0; m_last = 1;
      e_gnt = 2'b00; e_en = 8'h00; e_dp = 8'h00; e_data = 64'h0;
    end else begin
      if (m_gap > 0) begin
        m_gap = m_gap - 1;
        if (m_gap == 0) begin
          m_win = arb(req0, req1, m_last);
          if (m_win >= 0) begin m_owner = m_win; m_last = m_win; m_held = 0; end
        end
      end else if (m_owner >= 0) begin
        m_held = m_held + 1;
        if (!req_of(m_owner) || (m_held >= HOLD && req_of(1 - m_owner))) begin
          m_owner = -1;
          m_gap   = BLANK;
        end
      end else begin
        m_win = arb(req0, req1, m_last);
        if (m_win >= 0) begin m_owner = m_win; m_last = m_win; m_held = 0; end
      end
      if (m_owner == 0) begin
        e_gnt = 2'b01; e_en = en0; e_dp = dp0; e_data = digits0;
      end else if (m_owner == 1) begin
        e_gnt = 2'b10; e_en = en1; e_dp = dp1; e_data = digits1;
      end else begin
        e_gnt = 2'b00; e_en = 8'h00; e_dp = 8'h00;
      end
    end
  end

  // Compare DUT against the model shortly after every rising edge.
  always @(posedge HCLK) begin
    #1;
    n_vec = n_vec + 1;
    if (gnt !== e_gnt || seg_en !== e_en || seg_dp !== e_dp || seg_data !== e_data) begin
      n_bad = n_bad + 1;
      $display("FAIL model t=%0t got gnt=%b en=%h dp=%h data=%h want gnt=%b en=%h dp=%h data=%h",
               $time, gnt, seg_en, seg_dp, seg_data, e_gnt, e_en, e_dp, e_data);
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  logic [1:0] g [1:30];
  int         n01;
  int         nz;

  initial begin
    n_vec = 0; n_bad = 0;
    HRESET = 1'b1; req0 = 1'b1; req1 = 1'b1;
    en0 = 8'h0F; en1 = 8'hF0;
    digits0 = 64'h1111_2222_3333_4444; digits1 = 64'hAAAA_BBBB_CCCC_DDDD;
    dp0 = 8'h80; dp1 = 8'h02;

    // Reset with both requests high.
    tick(); tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_en", seg_en, 0);
    chk("rst_data", seg_data, 0);
    chk("rst_dp", seg_dp, 0);

    // Round-robin with both held high: 0 wins first.
    HRESET = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      g[c] = gnt;
    end
    chk("rr_c1", g[1], 2'b01);
    chk("rr_c8", g[8], 2'b01);
    chk("rr_c9", g[9], 2'b00);
    chk("rr_c10", g[10], 2'b00);
    chk("rr_c11", g[11], 2'b10);
    chk("rr_c18", g[18], 2'b10);
    chk("rr_c19", g[19], 2'b00);
    chk("rr_c21", g[21], 2'b01);
    chk("rr_c30", g[30], 2'b00);

    // Cycle 30 is the second blank cycle: reset there, then req0 must win again.
    HRESET = 1'b1;
    tick();
    chk("midblank_gnt", gnt, 0);
    chk("midblank_data", seg_data, 0);
    HRESET = 1'b0;
    tick();
    chk("post_rst_gnt", gnt, 2'b01);
    chk("post_rst_en", seg_en, 8'h0F);
    chk("post_rst_data", seg_data, 64'h1111_2222_3333_4444);

    // Owner releases at grant cycle 2 while the other is idle.
    req1 = 1'b0;
    tick();
    req0 = 1'b0;
    tick();
    chk("rel_gnt", gnt, 0);
    chk("rel_en", seg_en, 0);
    tick();
    chk("rel_blank2", gnt, 0);
    tick();
    chk("rel_idle_en", seg_en, 0);
    chk("rel_idle_data", seg_data, 64'h1111_2222_3333_4444);

    // Single owner, then data follows one cycle later.
    req1 = 1'b1; digits1 = 64'h0123456789ABCDEF; en1 = 8'hFF; dp1 = 8'h01;
    tick();
    chk("own_gnt", gnt, 2'b10);
    chk("own_data", seg_data, 64'h0123456789ABCDEF);
    chk("own_en", seg_en, 8'hFF);
    chk("own_dp", seg_dp, 8'h01);
    digits1 = 64'hFEDCBA9876543210;
    chk("own_data_pre", seg_data, 64'h0123456789ABCDEF);
    tick();
    chk("own_data_new", seg_data, 64'hFEDCBA9876543210);

    // Preemption: req0 owns, req1 arrives at grant cycle 3.
    req1 = 1'b0;
    repeat (4) tick();
    chk("pre_idle", gnt, 0);
    req0 = 1'b1;
    tick();
    tick();
    tick();
    req1 = 1'b1;
    n01 = 3;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt != 2'b01) break;
      n01 = n01 + 1;
    end
    chk("pre_hold", n01, HOLD);
    nz = 0;
    if (gnt == 2'b00) nz = 1;
    for (int i = 0; i < 20 && nz > 0; i++) begin
      tick();
      if (gnt != 2'b00) break;
      nz = nz + 1;
    end
    chk("pre_gap", nz, BLANK);
    chk("pre_new_gnt", gnt, 2'b10);

    repeat (12) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
